// File: rtl/branch_resolve_unit_if.sv
// Handshake bundle between fetch/execute and the branch resolve unit.
// The master drives pushes and resolves; the slave returns training, flush and status.
interface branch_resolve_unit_if #(
    parameter int PTR_BITS = 3,
    parameter int CNT_W    = 16
);
    logic                push_valid;
    logic [31:0]         push_pc;
    logic                push_pred_taken;
    logic [31:0]         push_pred_target;
    logic                push_ready;

    logic                res_valid;
    logic                res_taken;
    logic [31:0]         res_target;
    logic                res_ready;

    logic                upd_valid;
    logic [31:0]         upd_pc;
    logic                upd_taken;
    logic                flush;
    logic [31:0]         redirect_pc;
    logic [PTR_BITS:0]   count;
    logic [CNT_W-1:0]    mispredict_cnt;

    modport master (
        output push_valid, push_pc, push_pred_taken, push_pred_target,
        output res_valid, res_taken, res_target,
        input  push_ready, res_ready,
        input  upd_valid, upd_pc, upd_taken, flush, redirect_pc,
        input  count, mispredict_cnt
    );

    modport slave (
        input  push_valid, push_pc, push_pred_taken, push_pred_target,
        input  res_valid, res_taken, res_target,
        output push_ready, res_ready,
        output upd_valid, upd_pc, upd_taken, flush, redirect_pc,
        output count, mispredict_cnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// In-order queue of predicted branches; retires the oldest on resolve, trains the
// predictor and raises a one-cycle flush with the corrected PC on a mispredict.
module branch_resolve_unit #(
    parameter int DEPTH    = 8,
    parameter int PTR_BITS = 3,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_resolve_unit_if.slave  bus
);
    localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS + 1)'(DEPTH);

    logic [31:0]         pc_mem     [DEPTH];
    logic                taken_mem  [DEPTH];
    logic [31:0]         target_mem [DEPTH];

    logic [PTR_BITS-1:0] wr_ptr_reg;
    logic [PTR_BITS-1:0] rd_ptr_reg;
    logic [PTR_BITS:0]   count_reg;
    logic [PTR_BITS:0]   count_next;
    logic                upd_valid_reg;
    logic [31:0]         upd_pc_reg;
    logic                upd_taken_reg;
    logic                flush_reg;
    logic [31:0]         redirect_pc_reg;
    logic [CNT_W-1:0]    mispredict_cnt_reg;

    logic                push_ready;
    logic                res_ready;
    logic                push_fire;
    logic                res_fire;
    logic                mispredict;
    logic                mem_we;
    logic [31:0]         head_pc;
    logic                head_taken;
    logic [31:0]         head_target;
    logic [31:0]         redirect_next;

    assign push_ready = (count_reg != FULL_COUNT) && !flush_reg;
    assign res_ready  = (count_reg != '0);
    assign push_fire  = bus.push_valid && push_ready;
    assign res_fire   = bus.res_valid && res_ready;

    assign head_pc     = pc_mem[rd_ptr_reg];
    assign head_taken  = taken_mem[rd_ptr_reg];
    assign head_target = target_mem[rd_ptr_reg];

    // A taken/taken pair still mispredicts if the predicted target was wrong.
    assign mispredict = res_fire &&
                        ((head_taken != bus.res_taken) ||
                         (head_taken && bus.res_taken && (head_target != bus.res_target)));

    assign redirect_next = bus.res_taken ? bus.res_target : (head_pc + 32'd4);

    // A push that coincides with a mispredict belongs to the wrong path.
    assign mem_we = push_fire && !mispredict;

    always_comb begin
        count_next = count_reg;
        if (mispredict) begin
            count_next = '0;
        end else begin
            case ({mem_we, res_fire})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            pc_mem[wr_ptr_reg]     <= bus.push_pc;
            taken_mem[wr_ptr_reg]  <= bus.push_pred_taken;
            target_mem[wr_ptr_reg] <= bus.push_pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            count_reg          <= '0;
            upd_valid_reg      <= 1'b0;
            upd_pc_reg         <= '0;
            upd_taken_reg      <= 1'b0;
            flush_reg          <= 1'b0;
            redirect_pc_reg    <= '0;
            mispredict_cnt_reg <= '0;
        end else begin
            count_reg     <= count_next;
            upd_valid_reg <= res_fire;
            flush_reg     <= mispredict;
            if (res_fire) begin
                upd_pc_reg    <= head_pc;
                upd_taken_reg <= bus.res_taken;
            end
            if (mispredict) begin
                wr_ptr_reg      <= '0;
                rd_ptr_reg      <= '0;
                redirect_pc_reg <= redirect_next;
                if (mispredict_cnt_reg != '1) begin
                    mispredict_cnt_reg <= mispredict_cnt_reg + 1'b1;
                end
            end else begin
                if (mem_we) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (res_fire) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
            end
        end
    end

    assign bus.push_ready     = push_ready;
    assign bus.res_ready      = res_ready;
    assign bus.upd_valid      = upd_valid_reg;
    assign bus.upd_pc         = upd_pc_reg;
    assign bus.upd_taken      = upd_taken_reg;
    assign bus.flush          = flush_reg;
    assign bus.redirect_pc    = redirect_pc_reg;
    assign bus.count          = count_reg;
    assign bus.mispredict_cnt = mispredict_cnt_reg;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: queue ordering, training pulses,
// mispredict flush/redirect, full/wrap behaviour and mid-run reset.
module tb_branch_resolve_unit;
    logic clk;
    logic rst_n;
    int   checks_cnt;
    int   fail_cnt;

    branch_resolve_unit_if #(.PTR_BITS(3), .CNT_W(16)) bus ();

    branch_resolve_unit #(.DEPTH(8), .PTR_BITS(3), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end else begin
            $display("ok   %s value=0x%08h", tag, actual);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.push_valid       = 1'b0;
        bus.push_pc          = 32'h0;
        bus.push_pred_taken  = 1'b0;
        bus.push_pred_target = 32'h0;
        bus.res_valid        = 1'b0;
        bus.res_taken        = 1'b0;
        bus.res_target       = 32'h0;
    endtask

    task automatic do_push(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        bus.push_valid       = 1'b1;
        bus.push_pc          = pc;
        bus.push_pred_taken  = pt;
        bus.push_pred_target = tgt;
        tick();
        bus.push_valid       = 1'b0;
    endtask

    task automatic do_resolve(input logic taken, input logic [31:0] tgt);
        bus.res_valid  = 1'b1;
        bus.res_taken  = taken;
        bus.res_target = tgt;
        tick();
        bus.res_valid  = 1'b0;
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        rst_n      = 1'b0;
        clear_inputs();

        // 1: reset
        tick();
        tick();
        check_val("rst_count",      32'(bus.count), 32'd0);
        check_val("rst_push_ready", 32'(bus.push_ready), 32'd1);
        check_val("rst_res_ready",  32'(bus.res_ready), 32'd0);
        check_val("rst_upd_valid",  32'(bus.upd_valid), 32'd0);
        check_val("rst_upd_pc",     bus.upd_pc, 32'd0);
        check_val("rst_upd_taken",  32'(bus.upd_taken), 32'd0);
        check_val("rst_flush",      32'(bus.flush), 32'd0);
        check_val("rst_redirect",   bus.redirect_pc, 32'd0);
        check_val("rst_mcnt",       32'(bus.mispredict_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // 2: correct not-taken prediction
        do_push(32'h100, 1'b0, 32'h0);
        check_val("t2_count_after_push", 32'(bus.count), 32'd1);
        check_val("t2_res_ready",        32'(bus.res_ready), 32'd1);
        do_resolve(1'b0, 32'h0);
        check_val("t2_upd_valid", 32'(bus.upd_valid), 32'd1);
        check_val("t2_upd_pc",    bus.upd_pc, 32'h100);
        check_val("t2_upd_taken", 32'(bus.upd_taken), 32'd0);
        check_val("t2_flush",     32'(bus.flush), 32'd0);
        check_val("t2_count",     32'(bus.count), 32'd0);
        tick();
        check_val("t2_upd_valid_drop", 32'(bus.upd_valid), 32'd0);
        check_val("t2_upd_pc_hold",    bus.upd_pc, 32'h100);

        // 3: direction mispredicts
        do_push(32'h200, 1'b0, 32'h0);
        do_resolve(1'b1, 32'h400);
        check_val("t3a_flush",      32'(bus.flush), 32'd1);
        check_val("t3a_redirect",   bus.redirect_pc, 32'h400);
        check_val("t3a_upd_valid",  32'(bus.upd_valid), 32'd1);
        check_val("t3a_upd_pc",     bus.upd_pc, 32'h200);
        check_val("t3a_upd_taken",  32'(bus.upd_taken), 32'd1);
        check_val("t3a_mcnt",       32'(bus.mispredict_cnt), 32'd1);
        check_val("t3a_push_ready", 32'(bus.push_ready), 32'd0);
        tick();
        check_val("t3a_flush_drop", 32'(bus.flush), 32'd0);
        check_val("t3a_push_ready_back", 32'(bus.push_ready), 32'd1);
        do_push(32'h204, 1'b1, 32'h300);
        do_resolve(1'b0, 32'h0);
        check_val("t3b_flush",     32'(bus.flush), 32'd1);
        check_val("t3b_redirect",  bus.redirect_pc, 32'h208);
        check_val("t3b_upd_taken", 32'(bus.upd_taken), 32'd0);
        check_val("t3b_mcnt",      32'(bus.mispredict_cnt), 32'd2);
        tick();

        // 4: fill, overflow attempt, in-order drain, wrap
        for (int i = 0; i < 8; i++) begin
            do_push(32'h1000 + 32'(i * 4), 1'b0, 32'h0);
        end
        check_val("t4_count_full", 32'(bus.count), 32'd8);
        check_val("t4_push_ready", 32'(bus.push_ready), 32'd0);
        do_push(32'h2000, 1'b0, 32'h0);
        check_val("t4_overflow_count", 32'(bus.count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            do_resolve(1'b0, 32'h0);
            check_val($sformatf("t4_pop%0d_pc", i), bus.upd_pc, 32'h1000 + 32'(i * 4));
            check_val($sformatf("t4_pop%0d_count", i), 32'(bus.count), 32'(7 - i));
        end
        check_val("t4_flush_none", 32'(bus.flush), 32'd0);
        for (int i = 0; i < 5; i++) begin
            do_push(32'h3000 + 32'(i * 4), 1'b0, 32'h0);
        end
        check_val("t4_wrap_count", 32'(bus.count), 32'd5);
        // simultaneous push and correct resolve keeps occupancy
        bus.push_valid = 1'b1;
        bus.push_pc    = 32'h3014;
        bus.res_valid  = 1'b1;
        bus.res_taken  = 1'b0;
        tick();
        clear_inputs();
        check_val("t4_simul_count", 32'(bus.count), 32'd5);
        check_val("t4_simul_pc",    bus.upd_pc, 32'h3000);
        for (int i = 1; i < 6; i++) begin
            do_resolve(1'b0, 32'h0);
            check_val($sformatf("t4_wrap_pop%0d_pc", i), bus.upd_pc, 32'h3000 + 32'(i * 4));
        end
        check_val("t4_wrap_empty", 32'(bus.count), 32'd0);
        do_resolve(1'b1, 32'h999);
        check_val("t4_empty_res_upd", 32'(bus.upd_valid), 32'd0);
        check_val("t4_empty_res_flush", 32'(bus.flush), 32'd0);

        // 5: mispredict with a coincident push
        for (int i = 0; i < 4; i++) begin
            do_push(32'h4000 + 32'(i * 4), 1'b0, 32'h0);
        end
        bus.push_valid = 1'b1;
        bus.push_pc    = 32'h5000;
        bus.res_valid  = 1'b1;
        bus.res_taken  = 1'b1;
        bus.res_target = 32'h4800;
        tick();
        clear_inputs();
        check_val("t5_count",      32'(bus.count), 32'd0);
        check_val("t5_flush",      32'(bus.flush), 32'd1);
        check_val("t5_push_ready", 32'(bus.push_ready), 32'd0);
        check_val("t5_redirect",   bus.redirect_pc, 32'h4800);
        check_val("t5_mcnt",       32'(bus.mispredict_cnt), 32'd3);
        tick();
        check_val("t5_push_ready_back", 32'(bus.push_ready), 32'd1);
        check_val("t5_still_empty",     32'(bus.count), 32'd0);
        do_push(32'h6000, 1'b0, 32'h0);
        do_resolve(1'b0, 32'h0);
        check_val("t5_next_pc", bus.upd_pc, 32'h6000);

        // 6: target mispredict, then reset with entries queued
        do_push(32'h7000, 1'b1, 32'h500);
        do_resolve(1'b1, 32'h504);
        check_val("t6_flush",    32'(bus.flush), 32'd1);
        check_val("t6_redirect", bus.redirect_pc, 32'h504);
        check_val("t6_mcnt",     32'(bus.mispredict_cnt), 32'd4);
        tick();
        for (int i = 0; i < 3; i++) begin
            do_push(32'h8000 + 32'(i * 4), 1'b1, 32'h0);
        end
        check_val("t6_count_pre_rst", 32'(bus.count), 32'd3);
        rst_n         = 1'b0;
        bus.res_valid = 1'b1;
        bus.res_taken = 1'b0;
        tick();
        clear_inputs();
        check_val("t6_rst_upd_valid", 32'(bus.upd_valid), 32'd0);
        check_val("t6_rst_flush",     32'(bus.flush), 32'd0);
        check_val("t6_rst_count",     32'(bus.count), 32'd0);
        check_val("t6_rst_mcnt",      32'(bus.mispredict_cnt), 32'd0);
        rst_n = 1'b1;
        tick();
        check_val("t6_post_upd_valid", 32'(bus.upd_valid), 32'd0);
        check_val("t6_post_flush",     32'(bus.flush), 32'd0);
        check_val("t6_post_res_ready", 32'(bus.res_ready), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
